// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 9-bit combinational ALU: FIFO-buffers commands, issues them,
// captures results in order. Optional macro ALU_CMD_SEQUENCER_ILLEGAL_EN adds rsp_err.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    localparam int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic [3:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
    output logic              rsp_err,
`endif
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 4 + 2 * DATA_W + 1;
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RESP
    } state_t;

    state_t              state;
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [DATA_W-1:0]   acc;

    logic                push;
    logic                pop;
    logic                issue_alu;
    logic                fifo_empty;
    logic [3:0]          head_sel;
    logic [DATA_W-1:0]   head_a;
    logic [DATA_W-1:0]   head_b;
    logic                head_use_acc;

    assign {head_sel, head_a, head_b, head_use_acc} = mem[rd_ptr];

    assign fifo_empty = (count == '0);
    assign cmd_ready  = !rst && (count != FULL);
    assign push       = cmd_valid && cmd_ready;
    // Pop whenever the FSM is free to issue: idle, or the current response is being accepted.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign busy       = !rst && (!fifo_empty || (state != IDLE));

`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
    logic head_illegal;
    logic illegal_p1;
    assign head_illegal = (head_sel == 4'b1111);
    assign issue_alu    = pop && !head_illegal;
`else
    assign issue_alu    = pop;
`endif

    // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_sel, cmd_a, cmd_b, cmd_use_acc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc       <= '0;
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
            rsp_err    <= 1'b0;
            illegal_p1 <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // Issue stage: acc already holds the previous command's result here.
            if (issue_alu) begin
                alu_sel <= head_sel;
                alu_a   <= head_use_acc ? acc : head_a;
                alu_b   <= head_b;
            end
`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
            if (pop) begin
                illegal_p1 <= head_illegal;
            end
`endif

            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_valid <= 1'b1;
`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
                    if (illegal_p1) begin
                        rsp_data <= '0;
                        rsp_zero <= 1'b1;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_z;
                        rsp_zero <= (alu_z == '0);
                        rsp_err  <= 1'b0;
                        acc      <= alu_z;
                    end
`else
                    rsp_data <= alu_z;
                    rsp_zero <= (alu_z == '0);
                    acc      <= alu_z;
`endif
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? CAPTURE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: an ALU model closes the loop, and a queue-based reference
// model predicts every response, including operands seen by the ALU.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
    localparam bit ILLEGAL = 1'b1;
`else
    localparam bit ILLEGAL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_sel = '0;
    logic [8:0] cmd_a = '0;
    logic [8:0] cmd_b = '0;
    logic       cmd_use_acc = 1'b0;
    logic [3:0] alu_sel;
    logic [8:0] alu_a;
    logic [8:0] alu_b;
    logic [8:0] alu_z;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [8:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_err;
    logic       busy;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero),
`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );
`ifndef ALU_CMD_SEQUENCER_ILLEGAL_EN
    assign rsp_err = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_fn(input logic [3:0] s, input logic [8:0] a, input logic [8:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return {a[7:0], 1'b0};
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return {1'b0, a[8:1]};
            default: return a ^ 9'h0A5;
        endcase
    endfunction

    always_comb alu_z = alu_fn(alu_sel, alu_a, alu_b);

    typedef struct {
        logic [8:0] data;
        logic       zero;
        logic       err;
        logic [3:0] sel;
        logic [8:0] a;
        logic [8:0] b;
    } exp_t;

    exp_t       expq[$];
    exp_t       mon_e;
    logic [8:0] model_acc = '0;
    logic [3:0] last_sel = '0;
    logic [8:0] last_a = '0;
    logic [8:0] last_b = '0;

    int n_checks = 0;
    int n_fail = 0;
    int n_acc = 0;
    int cyc = 0;
    int last_hs_cyc = -1;
    bit tput_chk = 1'b0;
    bit rand_rdy = 1'b0;
    bit hold_prev = 1'b0;
    logic [8:0] held_data = '0;
    logic       held_zero = 1'b0;
    logic [8:0] last_rsp = '0;
    logic       last_zero = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: responses are in command order, so each one is fixed at accept time.
    function automatic void model_push(input logic [3:0] s, input logic [8:0] a,
                                       input logic [8:0] b, input logic ua);
        exp_t e;
        logic [8:0] opa;
        if (ILLEGAL && s == 4'b1111) begin
            e.data = '0; e.zero = 1'b1; e.err = 1'b1;
            e.sel = last_sel; e.a = last_a; e.b = last_b;
        end else begin
            opa = ua ? model_acc : a;
            e.data = alu_fn(s, opa, b);
            e.zero = (e.data == 9'd0);
            e.err = 1'b0;
            e.sel = s; e.a = opa; e.b = b;
            last_sel = s; last_a = opa; last_b = b;
            model_acc = e.data;
        end
        expq.push_back(e);
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                model_push(cmd_sel, cmd_a, cmd_b, cmd_use_acc);
                n_acc++;
            end
            if (rsp_valid) begin
                if (hold_prev) begin
                    chk("rsp_hold_data", rsp_data, held_data);
                    chk("rsp_hold_zero", rsp_zero, held_zero);
                end
                if (rsp_ready) begin
                    if (expq.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        mon_e = expq.pop_front();
                        chk("rsp_data", rsp_data, mon_e.data);
                        chk("rsp_zero", rsp_zero, mon_e.zero);
                        chk("rsp_err", rsp_err, mon_e.err);
                        chk("alu_sel", alu_sel, mon_e.sel);
                        chk("alu_a", alu_a, mon_e.a);
                        chk("alu_b", alu_b, mon_e.b);
                    end
                    last_rsp = rsp_data;
                    last_zero = rsp_zero;
                    if (tput_chk && last_hs_cyc >= 0) chk("rsp_gap", cyc - last_hs_cyc, 2);
                    last_hs_cyc = cyc;
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                    held_data = rsp_data;
                    held_zero = rsp_zero;
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic send(input logic [3:0] s, input logic [8:0] a, input logic [8:0] b, input logic ua);
        bit ok = 1'b0;
        cmd_sel = s; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic wait_idle(input int maxc);
        bit done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            done = !busy && !rsp_valid && (expq.size() == 0);
        end
        chk("drain", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        model_acc = '0; last_sel = '0; last_a = '0; last_b = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ac;
        bit seen;
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single add with latency and busy timing
        rsp_ready = 1'b1;
        cmd_sel = 4'd0; cmd_a = 9'd5; cmd_b = 9'd7; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        chk("add_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_t0", rsp_valid, 0);
        @(negedge clk);
        chk("lat_t1", rsp_valid, 0);
        @(negedge clk);
        chk("lat_t2", rsp_valid, 1);
        chk("busy_in_resp", busy, 1);
        @(negedge clk);
        chk("busy_after_hs", busy, 0);
        @(posedge clk);
        #1;
        chk("add_5_7", last_rsp, 12);

        // Chained back-to-back commands
        send(4'd0, 9'd3, 9'd4, 1'b0);
        send(4'd0, 9'd99, 9'd10, 1'b1);
        wait_idle(40);
        chk("chain_result", last_rsp, 17);

        // Wrap and op variety
        send(4'd0, 9'd300, 9'd300, 1'b0);
        wait_idle(40);
        chk("add_wrap", last_rsp, 88);
        send(4'd2, 9'd20, 9'd30, 1'b0);
        wait_idle(40);
        chk("mul_wrap", last_rsp, 88);
        send(4'd3, 9'h1FF, 9'd0, 1'b0);
        wait_idle(40);
        chk("shl_edge", last_rsp, 9'h1FE);
        send(4'd1, 9'd5, 9'd5, 1'b0);
        wait_idle(40);
        chk("sub_zero", last_rsp, 0);
        chk("sub_zero_flag", last_zero, 1);

        // Backpressure: DEPTH queued plus one held in RESP
        rsp_ready = 1'b0;
        n_acc = 0;
        cmd_sel = 4'd0; cmd_a = 9'd10; cmd_b = 9'd1; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ac = cmd_ready;
            @(posedge clk);
            #1;
            if (ac) begin
                cmd_a = cmd_a + 9'd11;
                cmd_b = cmd_b + 9'd3;
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", n_acc, DEPTH + 1);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        @(posedge clk);
        #1;
        last_hs_cyc = -1;
        tput_chk = 1'b1;
        rsp_ready = 1'b1;
        wait_idle(60);
        tput_chk = 1'b0;

        // Reset in RESP with three queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd0, 9'(40 + i), 9'd2, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("pre_rst_valid", seen, 1);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(4'd0, 9'd77, 9'd5, 1'b1);
        wait_idle(40);
        chk("post_rst_acc", last_rsp, 5);

`ifdef ALU_CMD_SEQUENCER_ILLEGAL_EN
        // Illegal op between two adds
        send(4'd0, 9'd3, 9'd4, 1'b0);
        send(4'b1111, 9'd1, 9'd1, 1'b0);
        send(4'd0, 9'd1, 9'd2, 1'b1);
        wait_idle(40);
        chk("illegal_skip_acc", last_rsp, 9);
`endif

        // Randomized traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 120; i++) begin
            send(4'($urandom_range(0, 15)), 9'($urandom), 9'($urandom), 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle(400);
        chk("queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
